// File: rtl/qpd_pkg.sv
// ---------------------------------------------------------------------------
// qpd_pkg
// Shared definitions for the multi-channel programmable-delay trigger:
//   - qpd_state_e : per-channel FSM state encoding (IDLE / DELAY / PULSE)
//   - FIRE_CNT_W  : width of the optional per-channel fire counter
//   - qpd_slice_lo: low bit index of channel ch in a bus of w-bit fields
// ---------------------------------------------------------------------------
package qpd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } qpd_state_e;

    localparam int FIRE_CNT_W = 16;

    // Low bit of channel ch's field in a flat bus of w-bit fields.
    function automatic int qpd_slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/qpd_channel.sv
// ---------------------------------------------------------------------------
// qpd_channel
// One trigger channel: rt edge detector, config latch, IDLE->DELAY->PULSE FSM
// and registered trigger/busy/done outputs.
// Optional feature macro: QPD_FIRE_COUNT_EN adds fire_count (count of trigger
// rising edges since the last arm, saturating).
// Ports:
//   sclock      in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rt          in   arm request, rising edge arms while idle
//   abort       in   synchronous abort, level
//   delay_cfg   in   delay D in cycles
//   pulse_cfg   in   pulse length P in cycles (0 treated as 1)
//   repeat_cfg  in   1 = periodic, 0 = one-shot
//   trigger     out  trigger pulse
//   busy        out  channel not idle
//   done        out  one-cycle pulse at one-shot completion
//   fire_count  out  (QPD_FIRE_COUNT_EN only) trigger rising-edge count
// ---------------------------------------------------------------------------
module qpd_channel
    import qpd_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int PULSE_W = 8
) (
    input  logic               sclock,
    input  logic               rst_n,
    input  logic               rt,
    input  logic               abort,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic [PULSE_W-1:0] pulse_cfg,
    input  logic               repeat_cfg,
`ifdef QPD_FIRE_COUNT_EN
    output logic [FIRE_CNT_W-1:0] fire_count,
`endif
    output logic               trigger,
    output logic               busy,
    output logic               done
);

    // One counter serves both phases, so it is as wide as the wider field.
    localparam int CNT_W = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    qpd_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] deff_r;
    logic [CNT_W-1:0] peff_r;
    logic             rpt_r;
    logic             rt_prev_r;
    logic             trigger_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] delay_ext_s;
    logic [CNT_W-1:0] pulse_ext_s;
    logic             arm_go_s;
    logic             delay_end_s;
    logic             pulse_go_s;

    // Arm / phase-transition strobes shared by the FSM and the fire counter.
    always_comb begin
        delay_ext_s = CNT_W'(delay_cfg);
        pulse_ext_s = CNT_W'(pulse_cfg);
        // Abort takes priority over a simultaneous arm edge.
        arm_go_s    = (state_r == ST_IDLE) && rt && !rt_prev_r && !abort;
        // Last DELAY cycle: cnt_r counts 1..deff_r inside the phase.
        delay_end_s = (state_r == ST_DELAY) && (cnt_r == deff_r);
        // Entry into PULSE, i.e. a trigger rising edge at the coming clock.
        pulse_go_s  = !abort && ((arm_go_s && (delay_ext_s == CNT_ZERO)) || delay_end_s);
    end

    // Channel FSM with registered outputs and config latch.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            deff_r    <= CNT_ZERO;
            peff_r    <= CNT_ZERO;
            rpt_r     <= 1'b0;
            rt_prev_r <= 1'b1;      // rt held high across reset release must not arm
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            rt_prev_r <= rt;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arm_go_s) begin
                        // Deff=max(D,1) is only consulted after the first
                        // DELAY, which is skipped when D=0.
                        deff_r <= (delay_ext_s == CNT_ZERO) ? CNT_ONE : delay_ext_s;
                        peff_r <= (pulse_ext_s == CNT_ZERO) ? CNT_ONE : pulse_ext_s;
                        rpt_r  <= repeat_cfg;
                        busy_r <= 1'b1;
                        cnt_r  <= CNT_ONE;
                        if (pulse_go_s) begin
                            state_r   <= ST_PULSE;
                            trigger_r <= 1'b1;
                        end else begin
                            state_r   <= ST_DELAY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        trigger_r <= 1'b0;
                        busy_r    <= 1'b0;
                        cnt_r     <= CNT_ZERO;
                    end else if (delay_end_s) begin
                        state_r   <= ST_PULSE;
                        trigger_r <= 1'b1;
                        cnt_r     <= CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        trigger_r <= 1'b0;
                        busy_r    <= 1'b0;
                        cnt_r     <= CNT_ZERO;
                    end else if (cnt_r == peff_r) begin
                        trigger_r <= 1'b0;
                        if (rpt_r) begin
                            state_r <= ST_DELAY;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    trigger_r <= 1'b0;
                    busy_r    <= 1'b0;
                    cnt_r     <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef QPD_FIRE_COUNT_EN
    logic [FIRE_CNT_W-1:0] fire_cnt_r;

    // Trigger rising-edge counter: cleared at arm, saturating, held when idle.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            fire_cnt_r <= {FIRE_CNT_W{1'b0}};
        end else if (arm_go_s) begin
            // D=0 fires on the arm edge itself, so it already counts as one.
            fire_cnt_r <= pulse_go_s ? FIRE_CNT_W'(1'b1) : {FIRE_CNT_W{1'b0}};
        end else if (pulse_go_s && (fire_cnt_r != {FIRE_CNT_W{1'b1}})) begin
            fire_cnt_r <= fire_cnt_r + FIRE_CNT_W'(1'b1);
        end else begin
            fire_cnt_r <= fire_cnt_r;
        end
    end

    assign fire_count = fire_cnt_r;
`else
    // Fire counting disabled: no counter state exists in this build.
`endif

    assign trigger = trigger_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: rtl/qpd_multi_trigger.sv
// ---------------------------------------------------------------------------
// qpd_multi_trigger
// Multi-channel programmable-delay trigger generator. Generates NUM_CH
// independent qpd_channel instances and slices the flat config/output buses.
// Optional feature macro: QPD_FIRE_COUNT_EN adds fire_count.
// Ports:
//   sclock      in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rt          in   [NUM_CH]            per-channel arm request (rising edge)
//   abort       in   [NUM_CH]            per-channel synchronous abort
//   delay_cfg   in   [NUM_CH*DELAY_W]    per-channel delay D
//   pulse_cfg   in   [NUM_CH*PULSE_W]    per-channel pulse length P
//   repeat_cfg  in   [NUM_CH]            1 = periodic, 0 = one-shot
//   trigger     out  [NUM_CH]            trigger pulses
//   busy        out  [NUM_CH]            channel armed
//   done        out  [NUM_CH]            one-shot completion pulse
//   fire_count  out  [NUM_CH*16]         (QPD_FIRE_COUNT_EN only)
// SAMPLE_FREQUENCY is the sclock rate in Hz and carries no logic.
// ---------------------------------------------------------------------------
module qpd_multi_trigger
    import qpd_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DELAY_W          = 16,
    parameter int PULSE_W          = 8,
    parameter int SAMPLE_FREQUENCY = 100000
) (
    input  logic                       sclock,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          rt,
    input  logic [NUM_CH-1:0]          abort,
    input  logic [NUM_CH*DELAY_W-1:0]  delay_cfg,
    input  logic [NUM_CH*PULSE_W-1:0]  pulse_cfg,
    input  logic [NUM_CH-1:0]          repeat_cfg,
`ifdef QPD_FIRE_COUNT_EN
    output logic [NUM_CH*FIRE_CNT_W-1:0] fire_count,
`endif
    output logic [NUM_CH-1:0]          trigger,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          done
);

    // A non-positive sclock rate is a configuration error.
    if (SAMPLE_FREQUENCY < 1) begin : g_bad_freq
        $error("qpd_multi_trigger: SAMPLE_FREQUENCY must be positive");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        qpd_channel #(
            .DELAY_W (DELAY_W),
            .PULSE_W (PULSE_W)
        ) u_ch (
            .sclock     (sclock),
            .rst_n      (rst_n),
            .rt         (rt[i]),
            .abort      (abort[i]),
            .delay_cfg  (delay_cfg[qpd_slice_lo(i, DELAY_W) +: DELAY_W]),
            .pulse_cfg  (pulse_cfg[qpd_slice_lo(i, PULSE_W) +: PULSE_W]),
            .repeat_cfg (repeat_cfg[i]),
`ifdef QPD_FIRE_COUNT_EN
            .fire_count (fire_count[qpd_slice_lo(i, FIRE_CNT_W) +: FIRE_CNT_W]),
`endif
            .trigger    (trigger[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule
